fetch_prefetch_unit: RTL and testbench

//  Parametrised instruction fetch stage. Owns the PC, issues word requests to instruction memory over a

---
 rtl/fetch_prefetch_unit_if.sv | 31 +++
 rtl/fetch_prefetch_unit.sv | 126 ++++++++++++
 tb/tb_fetch_prefetch_unit.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_prefetch_unit_if.sv
// Fetch stage bus bundle: imem request/response, redirect and fetch-to-decode handshake.
// The master modport is the fetch unit's view; slave is the environment's view.
interface fetch_prefetch_unit_if #(
    parameter int XLEN = 32
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            fd_valid;
    logic            fd_ready;
    logic [XLEN-1:0] fd_inst_code;
    logic [XLEN-1:0] fd_pc;

    modport master (
        output imem_req_valid, imem_req_addr,
        output fd_valid, fd_inst_code, fd_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc, fd_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        input  fd_valid, fd_inst_code, fd_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc, fd_ready
    );
endinterface

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch stage: owns the PC, issues imem requests, buffers words for decode.
// A redirect flushes the prefetch FIFO and drops every response still in flight.
module fetch_prefetch_unit #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 4,
    parameter int              MAX_OUTST  = 4
) (
    input logic                    clock,
    input logic                    reset_n,
    fetch_prefetch_unit_if.master  bus
);
    localparam int FAW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int TAW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int FCW = $clog2(FIFO_DEPTH + 1);
    localparam int OCW = $clog2(MAX_OUTST + 1);

    typedef enum logic {RUN, DRAIN} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [OCW-1:0]  outst_q, outst_d;
    logic [OCW-1:0]  drop_q, drop_d;
    logic [TAW-1:0]  twp_q, twp_d, trp_q, trp_d;
    logic [FAW-1:0]  fwp_q, fwp_d, frp_q, frp_d;
    logic [FCW-1:0]  cnt_q, cnt_d;

    logic [XLEN-1:0] tag_q  [MAX_OUTST];
    logic [XLEN-1:0] inst_q [FIFO_DEPTH];
    logic [XLEN-1:0] pcs_q  [FIFO_DEPTH];

    logic            redir, req_v, acc, rsp, keep, pop, fd_v;
    logic [XLEN-1:0] tgt;

    assign tgt   = bus.redirect_pc & ~XLEN'(3);
    assign redir = bus.redirect_valid;
    assign rsp   = bus.imem_rsp_valid;
    assign fd_v  = (cnt_q != '0);
    assign pop   = fd_v && bus.fd_ready;

    // Credits count both buffered and in-flight words so the FIFO can never overflow.
    assign req_v = reset_n && !redir
                && (32'(outst_q) + 32'(cnt_q) < FIFO_DEPTH)
                && (32'(outst_q) < MAX_OUTST);
    assign acc   = req_v && bus.imem_req_ready;
    assign keep  = rsp && (state_q == RUN) && !redir;

    assign bus.imem_req_valid = req_v;
    assign bus.imem_req_addr  = pc_q;
    assign bus.fd_valid       = fd_v;
    assign bus.fd_inst_code   = fd_v ? inst_q[frp_q] : '0;
    assign bus.fd_pc          = fd_v ? pcs_q[frp_q] : '0;

    always_comb begin
        pc_d    = pc_q;
        outst_d = outst_q + OCW'(acc) - OCW'(rsp);
        drop_d  = drop_q;
        state_d = state_q;
        twp_d   = twp_q;
        trp_d   = trp_q;
        fwp_d   = fwp_q;
        frp_d   = frp_q;
        cnt_d   = cnt_q + FCW'(keep) - FCW'(pop);

        unique case (1'b1)
            redir:   pc_d = tgt;
            acc:     pc_d = pc_q + XLEN'(4);
            default: pc_d = pc_q;
        endcase

        if (acc)
            twp_d = (32'(twp_q) == MAX_OUTST - 1) ? '0 : twp_q + TAW'(1);
        if (rsp)
            trp_d = (32'(trp_q) == MAX_OUTST - 1) ? '0 : trp_q + TAW'(1);

        if (keep) fwp_d = fwp_q + FAW'(1);
        if (pop)  frp_d = frp_q + FAW'(1);

        // Everything still in flight after a redirect belongs to the old path.
        if (redir) begin
            drop_d = outst_d;
            cnt_d  = '0;
            frp_d  = fwp_q;
        end else if (rsp && state_q == DRAIN) begin
            drop_d = drop_q - OCW'(1);
        end

        state_d = (drop_d != '0) ? DRAIN : RUN;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            outst_q <= '0;
            drop_q  <= '0;
            twp_q   <= '0;
            trp_q   <= '0;
            fwp_q   <= '0;
            frp_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            outst_q <= outst_d;
            drop_q  <= drop_d;
            twp_q   <= twp_d;
            trp_q   <= trp_d;
            fwp_q   <= fwp_d;
            frp_q   <= frp_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clock) begin
        if (acc) tag_q[twp_q] <= pc_q;
        if (keep) begin
            inst_q[fwp_q] <= bus.imem_rsp_data;
            pcs_q[fwp_q]  <= tag_q[trp_q];
        end
    end

    rsp_needs_req: assert property (@(posedge clock) disable iff (!reset_n)
        !(bus.imem_rsp_valid && outst_q == '0));

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit with an in-order variable-latency imem model.
// A second instance with a wrapping reset PC checks address roll-over.
module tb_fetch_prefetch_unit;
    logic clk;
    logic rst_n;
    logic rst2_n;
    int   tests;
    int   fails;
    int   lat;
    int   cyc;
    logic [31:0] pq[$];
    int          dq[$];

    fetch_prefetch_unit_if #(.XLEN(32)) b();
    fetch_prefetch_unit_if #(.XLEN(32)) b2();

    fetch_prefetch_unit #(
        .XLEN(32), .RESET_PC(32'h0), .FIFO_DEPTH(4), .MAX_OUTST(4)
    ) u1 (
        .clock(clk), .reset_n(rst_n), .bus(b)
    );

    fetch_prefetch_unit #(
        .XLEN(32), .RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(4), .MAX_OUTST(4)
    ) u2 (
        .clock(clk), .reset_n(rst2_n), .bus(b2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0013;
    endfunction

    // In-order memory: a response is visible the cycle after its due edge.
    always @(posedge clk) begin
        cyc = cyc + 1;
        b.imem_rsp_valid <= 1'b0;
        if (!rst_n) begin
            pq.delete();
            dq.delete();
        end else begin
            if (b.imem_req_valid && b.imem_req_ready) begin
                pq.push_back(b.imem_req_addr);
                dq.push_back(cyc + lat - 1);
            end
            if (dq.size() > 0 && dq[0] <= cyc) begin
                b.imem_rsp_valid <= 1'b1;
                b.imem_rsp_data  <= mem_word(pq[0]);
                void'(pq.pop_front());
                void'(dq.pop_front());
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_fd(input logic [31:0] pc, input string tag);
        int n;
        n = 0;
        while (!(b.fd_valid && b.fd_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, 32'(b.fd_valid), 32'h1);
        chk({tag, "_pc"}, b.fd_pc, pc);
        chk({tag, "_inst"}, b.fd_inst_code, mem_word(pc));
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_reqv"}, 32'(b.imem_req_valid), 32'h0);
        chk({tag, "_addr"}, b.imem_req_addr, 32'h0);
        chk({tag, "_fdv"}, 32'(b.fd_valid), 32'h0);
        chk({tag, "_inst"}, b.fd_inst_code, 32'h0);
        chk({tag, "_fdpc"}, b.fd_pc, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_n;
        tests = 0;
        fails = 0;
        cyc = 0;
        lat = 1;
        rst_n = 1'b0;
        rst2_n = 1'b0;
        b.imem_req_ready = 1'b1;
        b.imem_rsp_valid = 1'b0;
        b.imem_rsp_data  = '0;
        b.redirect_valid = 1'b0;
        b.redirect_pc    = '0;
        b.fd_ready       = 1'b1;
        b2.imem_req_ready = 1'b1;
        b2.imem_rsp_valid = 1'b0;
        b2.imem_rsp_data  = '0;
        b2.redirect_valid = 1'b0;
        b2.redirect_pc    = '0;
        b2.fd_ready       = 1'b0;

        // 1: streaming at one word per cycle
        repeat (2) @(negedge clk);
        chk_reset_outs("rst");
        rst_n = 1'b1;
        #1;
        chk("t1_reqv", 32'(b.imem_req_valid), 32'h1);
        chk("t1_addr0", b.imem_req_addr, 32'h0);
        @(negedge clk);
        chk("t1_lat_empty", 32'(b.fd_valid), 32'h0);
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            chk("t1_backtoback", 32'(b.fd_valid), 32'h1);
            expect_fd(32'(i * 4), "t1");
        end

        // 2: decode stall fills exactly FIFO_DEPTH
        b.fd_ready = 1'b0;
        do_reset();
        acc_n = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (b.imem_req_valid && b.imem_req_ready) acc_n++;
            @(negedge clk);
        end
        chk("t2_issued", 32'(acc_n), 32'd4);
        chk("t2_reqv_off", 32'(b.imem_req_valid), 32'h0);
        b.fd_ready = 1'b1;
        expect_fd(32'h0, "t2_d0");
        chk("t2_resume_addr", b.imem_req_addr, 32'h10);
        chk("t2_resume_v", 32'(b.imem_req_valid), 32'h1);
        expect_fd(32'h4, "t2_d1");
        expect_fd(32'h8, "t2_d2");
        expect_fd(32'hC, "t2_d3");
        expect_fd(32'h10, "t2_d4");

        // 3: redirect with three requests in flight at latency 3
        lat = 3;
        do_reset();
        repeat (3) @(negedge clk);
        b.redirect_valid = 1'b1;
        b.redirect_pc    = 32'h103;
        #1;
        chk("t3_noreq", 32'(b.imem_req_valid), 32'h0);
        @(negedge clk);
        b.redirect_valid = 1'b0;
        #1;
        chk("t3_flush", 32'(b.fd_valid), 32'h0);
        chk("t3_addr", b.imem_req_addr, 32'h100);
        @(negedge clk);
        expect_fd(32'h100, "t3_a");
        expect_fd(32'h104, "t3_b");
        expect_fd(32'h108, "t3_c");

        // 3b: back-to-back redirects, last one wins
        b.redirect_valid = 1'b1;
        b.redirect_pc    = 32'h300;
        @(negedge clk);
        b.redirect_pc    = 32'h400;
        @(negedge clk);
        b.redirect_valid = 1'b0;
        expect_fd(32'h400, "t3b_a");
        expect_fd(32'h404, "t3b_b");

        // 4: redirect while a response arrives and the FIFO holds data
        lat = 1;
        do_reset();
        @(negedge clk);
        expect_fd(32'h0, "t4_pre0");
        expect_fd(32'h4, "t4_pre1");
        b.redirect_valid = 1'b1;
        b.redirect_pc    = 32'h2000;
        #1;
        chk("t4_noreq", 32'(b.imem_req_valid), 32'h0);
        @(negedge clk);
        b.redirect_valid = 1'b0;
        expect_fd(32'h2000, "t4_a");
        expect_fd(32'h2004, "t4_b");

        // 5: PC wrap from a high reset vector
        rst2_n = 1'b1;
        #1;
        chk("t5_v0", 32'(b2.imem_req_valid), 32'h1);
        chk("t5_a0", b2.imem_req_addr, 32'hFFFF_FFF8);
        @(negedge clk);
        chk("t5_a1", b2.imem_req_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        chk("t5_a2", b2.imem_req_addr, 32'h0000_0000);
        @(negedge clk);
        chk("t5_a3", b2.imem_req_addr, 32'h0000_0004);
        chk("t5_v3", 32'(b2.imem_req_valid), 32'h1);
        @(negedge clk);
        chk("t5_stop", 32'(b2.imem_req_valid), 32'h0);

        // 6: async reset with buffered and in-flight words
        lat = 3;
        b.fd_ready = 1'b0;
        do_reset();
        repeat (5) @(negedge clk);
        chk("t6_busy", 32'(b.fd_valid), 32'h1);
        rst_n = 1'b0;
        #1;
        chk_reset_outs("t6_rst");
        repeat (2) @(negedge clk);
        lat = 1;
        b.fd_ready = 1'b1;
        rst_n = 1'b1;
        #1;
        chk("t6_addr", b.imem_req_addr, 32'h0);
        @(negedge clk);
        expect_fd(32'h0, "t6_a");
        expect_fd(32'h4, "t6_b");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
